inst_fetch_assembler: RTL and testbench

//  Fetch sequencer sitting directly upstream of the byte-wide instruction memory. Drives

---
 rtl/inst_fetch_assembler.sv | 154 +++++++++++++++
 tb/tb_inst_fetch_assembler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_assembler.sv
// Fetch sequencer for a byte-wide, registered-output instruction memory.
// Collects four bytes per instruction and hands big-endian words to decode over valid/ready.
module inst_fetch_assembler #(
  parameter int          MEM_BYTES = 64,
  parameter logic [63:0] RESET_PC  = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] pc,
  output logic        stop,
  input  logic [7:0]  inst,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        fault
);

  localparam logic signed [63:0] LP_MAX_PC = 64'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_RUN,
    S_HOLD,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [2:0]         r_k;
  logic signed [63:0] r_base;
  logic [23:0]        r_acc;
  logic [31:0]        r_instr;
  logic [63:0]        r_instr_pc;
  logic               r_valid;
  logic               r_fault;

  state_t             w_state_nxt;
  logic [2:0]         w_k_nxt;
  logic signed [63:0] w_base_nxt;
  logic               w_valid_nxt;
  logic               w_fault_nxt;
  logic               w_capture;
  logic               w_complete;
  logic signed [63:0] w_redir_base;
  logic signed [63:0] w_inc_base;
  logic               w_redir_ok;
  logic               w_inc_ok;
  logic [2:0]         w_off;

  function automatic logic f_legal(input logic signed [63:0] a);
    return (a >= 64'sd0) && (a <= LP_MAX_PC);
  endfunction

  assign w_redir_base = redirect_pc & ~64'h3;
  assign w_inc_base   = r_base + 64'sd4;
  assign w_redir_ok   = f_legal(w_redir_base);
  assign w_inc_ok     = f_legal(w_inc_base);

  // Priority: halt, then redirect (beats a same-cycle accept), then normal sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_base_nxt  = r_base;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    if (halt) begin
      w_state_nxt = S_HALT;
      w_k_nxt     = '0;
      w_valid_nxt = 1'b0;
    end else if (redirect) begin
      w_base_nxt  = w_redir_base;
      w_k_nxt     = '0;
      w_valid_nxt = 1'b0;
      w_state_nxt = w_redir_ok ? S_RUN : S_HALT;
      w_fault_nxt = ~w_redir_ok;
    end else begin
      unique case (r_state)
        S_RUN: begin
          w_capture = (r_k != 3'd0);
          if (r_k == 3'd4) begin
            w_complete  = 1'b1;
            w_state_nxt = S_HOLD;
            w_valid_nxt = 1'b1;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + 3'd1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_base_nxt  = w_inc_base;
            w_valid_nxt = 1'b0;
            w_k_nxt     = '0;
            w_state_nxt = w_inc_ok ? S_RUN : S_HALT;
            w_fault_nxt = r_fault | ~w_inc_ok;
          end
        end
        S_HALT: begin
          // A fault halt only leaves through a legal redirect (handled above).
          if (!r_fault) begin
            w_state_nxt = S_RUN;
            w_k_nxt     = '0;
          end
        end
        default: w_state_nxt = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_k        <= '0;
      r_base     <= RESET_PC;
      r_acc      <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_base  <= w_base_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
      if (w_capture && !w_complete) begin
        r_acc <= {r_acc[15:0], inst};
      end
      if (w_complete) begin
        r_instr    <= {r_acc, inst};
        r_instr_pc <= r_base;
      end
    end
  end

  always_comb begin
    w_off = '0;
    if (r_state == S_RUN) begin
      w_off = (r_k == 3'd4) ? 3'd3 : r_k;
    end
  end

  assign pc          = r_base + {61'd0, w_off};
  assign stop        = !reset_n || !((r_state == S_RUN) && (r_k < 3'd4));
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_inst_fetch_assembler.sv
// Bench for inst_fetch_assembler: directed scenarios plus a randomized run checked
// against a cycle-count/queue-free model of fetch latency, PC sequencing and faults.
module tb_inst_fetch_assembler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] pc;
  logic        stop;
  logic [7:0]  inst = '0;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:63];

  inst_fetch_assembler #(.MEM_BYTES(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .stop(stop), .inst(inst),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  // Registered byte memory: returns 0 when stopped or out of range.
  always @(posedge clk) inst <= (stop || pc > 64'd63) ? 8'h00 : mem[pc[5:0]];

  function automatic logic [31:0] word_at(input logic [63:0] b);
    int a;
    a = int'(b[5:0]);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", instr); end
    vectors++; if (instr_pc !== 64'h0) begin miscompares++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b exp 0", fault); end
    vectors++; if (stop !== 1'b1) begin miscompares++; $display("FAIL reset_stop got %b exp 1", stop); end
  endtask

  task automatic test_first_fetch;
    int n;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pc !== 64'(i)) begin miscompares++; $display("FAIL first_pc[%0d] got %h exp %h", i, pc, 64'(i)); end
      vectors++; if (stop !== 1'b0) begin miscompares++; $display("FAIL first_stop[%0d] got %b exp 0", i, stop); end
      tick;
    end
    vectors++; if (stop !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL first_k4 got stop=%b valid=%b exp stop=1 valid=0", stop, instr_valid); end
    wait_valid(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL first_latency got %0d extra edges exp 1", n); end
    vectors++; if (instr !== 32'hF8000401) begin miscompares++; $display("FAIL first_instr got %h exp F8000401", instr); end
    vectors++; if (instr_pc !== 64'h0) begin miscompares++; $display("FAIL first_instr_pc got %h exp 0", instr_pc); end
    vectors++; if (pc !== 64'h0 || stop !== 1'b1) begin miscompares++; $display("FAIL hold_pc got pc=%h stop=%b exp 0/1", pc, stop); end
  endtask

  task automatic test_hold_accept;
    int n;
    instr_ready = 1'b0;
    repeat (3) begin
      tick;
      vectors++; if (instr_valid !== 1'b1 || instr !== 32'hF8000401) begin miscompares++; $display("FAIL hold_stable got valid=%b instr=%h exp 1/F8000401", instr_valid, instr); end
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL accept_drop got %b exp 0", instr_valid); end
    wait_valid(n);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL accept_latency got %0d exp 5", n); end
    vectors++; if (instr !== 32'hFC400423) begin miscompares++; $display("FAIL second_instr got %h exp FC400423", instr); end
    vectors++; if (instr_pc !== 64'h4) begin miscompares++; $display("FAIL second_instr_pc got %h exp 4", instr_pc); end
  endtask

  task automatic test_redirect;
    logic [63:0] targets [2];
    logic [63:0] nb;
    int n;
    targets[0] = 64'h18;
    targets[1] = 64'h1B;
    for (int t = 0; t < 2; t++) begin
      nb = instr_pc + 64'd4;
      instr_ready = 1'b1;
      tick;
      instr_ready = 1'b0;
      tick;
      tick;
      vectors++; if (pc !== nb + 64'd2) begin miscompares++; $display("FAIL redir_k2_pc got %h exp %h", pc, nb + 64'd2); end
      redirect = 1'b1;
      redirect_pc = targets[t];
      tick;
      redirect = 1'b0;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %b exp 0", instr_valid); end
      wait_valid(n);
      vectors++; if (n !== 5) begin miscompares++; $display("FAIL redir_latency got %0d exp 5", n); end
      vectors++; if (instr !== 32'hD2BFFFED || instr_pc !== 64'h18) begin miscompares++; $display("FAIL redir_word got %h@%h exp D2BFFFED@18", instr, instr_pc); end
    end
  endtask

  task automatic test_fault;
    int n;
    redirect = 1'b1; redirect_pc = 64'd64;
    tick;
    redirect = 1'b0;
    vectors++; if (fault !== 1'b1 || instr_valid !== 1'b0 || stop !== 1'b1) begin miscompares++; $display("FAIL fault_64 got f=%b v=%b s=%b exp 1/0/1", fault, instr_valid, stop); end
    repeat (3) tick;
    vectors++; if (fault !== 1'b1 || stop !== 1'b1) begin miscompares++; $display("FAIL fault_sticky got f=%b s=%b exp 1/1", fault, stop); end
    redirect = 1'b1; redirect_pc = 64'd60;
    tick;
    redirect = 1'b0;
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_clear60 got %b exp 0", fault); end
    wait_valid(n);
    vectors++; if (n !== 5 || instr !== word_at(64'd60) || instr_pc !== 64'd60) begin miscompares++; $display("FAIL last_word got n=%0d %h@%h exp 5 %h@3c", n, instr, instr_pc, word_at(64'd60)); end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    vectors++; if (fault !== 1'b1 || instr_valid !== 1'b0 || stop !== 1'b1) begin miscompares++; $display("FAIL fault_overrun got f=%b v=%b s=%b exp 1/0/1", fault, instr_valid, stop); end
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    redirect = 1'b0;
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_negative got %b exp 1", fault); end
    redirect = 1'b1; redirect_pc = 64'd0;
    tick;
    redirect = 1'b0;
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_clear0 got %b exp 0", fault); end
    wait_valid(n);
    vectors++; if (instr !== 32'hF8000401 || instr_pc !== 64'h0) begin miscompares++; $display("FAIL fault_recover got %h@%h exp F8000401@0", instr, instr_pc); end
  endtask

  task automatic test_halt;
    int n;
    halt = 1'b1;
    tick;
    vectors++; if (instr_valid !== 1'b0 || stop !== 1'b1) begin miscompares++; $display("FAIL halt_enter got v=%b s=%b exp 0/1", instr_valid, stop); end
    repeat (4) tick;
    vectors++; if (instr_valid !== 1'b0 || stop !== 1'b1 || pc !== 64'h0) begin miscompares++; $display("FAIL halt_hold got v=%b s=%b pc=%h exp 0/1/0", instr_valid, stop, pc); end
    halt = 1'b0;
    wait_valid(n);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL halt_latency got %0d exp 6", n); end
    vectors++; if (instr !== 32'hF8000401 || instr_pc !== 64'h0) begin miscompares++; $display("FAIL halt_refetch got %h@%h exp F8000401@0", instr, instr_pc); end
  endtask

  task automatic test_reset_midfetch;
    int n;
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    repeat (3) tick;
    vectors++; if (pc !== 64'd7) begin miscompares++; $display("FAIL mid_k3_pc got %h exp 7", pc); end
    reset_n = 1'b0;
    #1;
    vectors++; if (instr !== 32'h0 || instr_pc !== 64'h0 || instr_valid !== 1'b0 || fault !== 1'b0 || stop !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset got %h@%h v=%b f=%b s=%b exp 0@0 0/0/1", instr, instr_pc, instr_valid, fault, stop); end
    tick;
    reset_n = 1'b1;
    wait_valid(n);
    vectors++; if (n !== 5 || instr !== 32'hF8000401 || instr_pc !== 64'h0) begin miscompares++; $display("FAIL mid_restart got n=%0d %h@%h exp 5 F8000401@0", n, instr, instr_pc); end
  endtask

  task automatic test_random;
    logic signed [63:0] eb;
    logic signed [63:0] rps;
    int since;
    bit ef;
    bit ev;
    bit rd;
    int r;
    eb = 64'sd0; since = 5; ef = 1'b0;
    for (int c = 0; c < 400; c++) begin
      ev = !ef && (since >= 5);
      vectors++; if (instr_valid !== ev) begin miscompares++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, instr_valid, ev); end
      vectors++; if (fault !== ef) begin miscompares++; $display("FAIL rnd_fault c=%0d got %b exp %b", c, fault, ef); end
      if (ev) begin
        vectors++; if (instr_pc !== eb || instr !== word_at(eb)) begin miscompares++; $display("FAIL rnd_word c=%0d got %h@%h exp %h@%h", c, instr, instr_pc, word_at(eb), eb); end
      end
      rd = ef || ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 79)) - 8;
      rps = r;
      redirect = rd;
      redirect_pc = rps;
      instr_ready = $urandom_range(0, 1) == 1;
      if (rd) begin
        eb = rps & ~64'sd3;
        if (eb >= 0 && eb <= 60) begin ef = 1'b0; since = 0; end
        else ef = 1'b1;
      end else if (!ef) begin
        if (ev && instr_ready) begin
          eb = eb + 64'sd4;
          if (eb > 60) ef = 1'b1; else since = 0;
        end else if (since < 5) begin
          since++;
        end
      end
      tick;
    end
    redirect = 1'b0;
    instr_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]} = 32'hF8000401;
    {mem[4], mem[5], mem[6], mem[7]} = 32'hFC400423;
    {mem[24], mem[25], mem[26], mem[27]} = 32'hD2BFFFED;
    test_reset;
    test_first_fetch;
    test_hold_accept;
    test_redirect;
    test_fault;
    test_halt;
    test_reset_midfetch;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
